pc_branch_unit: RTL and testbench

Next-PC stage directly downstream of branch_comparator in the single-cycle 64-bit CPU. Consumes the equal/not_equal flags plus decoder branch/jump controls. Owns the architectural PC register and selects sequential, branch, jump or jump-register targets each cycle. Adds stall/halt control, a boot/run/halt state machine, misalignment detection and branch statistics counters.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/sat_counter.sv | 26 ++
 rtl/pc_branch_unit.sv | 150 +++++++++++++++
 tb/tb_pc_branch_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the next-PC stage: control-state and target-select codes,
// plus the sequential PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } pc_sel_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // count register: clears on reset, increments on inc until saturated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pc_branch_unit.sv
// Next-PC stage: owns the architectural PC, resolves branch/jump targets,
// sequences BOOT/RUN/HALT and keeps sticky error flags and branch statistics.
module pc_branch_unit
  import cpu_pkg::*;
#(
  parameter int          WIDTH    = 64,
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          IMM_W    = 16,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             beq,
  input  logic             bne,
  input  logic             jump,
  input  logic             jr,
  input  logic             equal,
  input  logic             not_equal,
  input  logic [IMM_W-1:0] imm,
  input  logic [25:0]      jtarget,
  input  logic [WIDTH-1:0] rs_val,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             pc_valid,
  output logic             taken,
  output logic             halted,
  output logic             misalign,
  output logic             cmp_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  state_e           state_r, state_nxt_s;
  pc_sel_e          sel_s;
  logic [WIDTH-1:0] pc_r, pc_nxt_s, pc_plus4_s, imm_ext_s, br_target_s, j_target_s;
  logic             misalign_r, cmp_err_r;
  logic             cond_s, is_branch_s, in_run_s, jr_mis_s, advance_s, commit_s;
  logic             inc_branch_s, inc_taken_s;

  assign pc_plus4_s  = pc_r + WIDTH'(PC_STEP);
  assign imm_ext_s   = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign br_target_s = pc_plus4_s + (imm_ext_s << 2);
  assign j_target_s  = {pc_plus4_s[WIDTH-1:28], jtarget, 2'b00};

  assign cond_s      = (beq & equal) | (bne & not_equal);
  assign is_branch_s = beq | bne;
  assign in_run_s    = (state_r == RUN);
  assign jr_mis_s    = jr & (rs_val[1:0] != 2'b00);
  // halt_req outranks stall; a misaligned jr halts instead of committing
  assign advance_s   = in_run_s & ~halt_req & ~stall;
  assign commit_s    = advance_s & ~jr_mis_s;

  assign inc_branch_s = commit_s & is_branch_s & ~jr & ~jump;
  assign inc_taken_s  = commit_s & cond_s & ~jr & ~jump;

  // target select by priority: jr > jump > conditional > sequential
  always_comb begin
    sel_s = SEL_SEQ;
    if (jr) begin
      sel_s = SEL_JR;
    end else if (jump) begin
      sel_s = SEL_J;
    end else if (cond_s) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  // target mux
  always_comb begin
    pc_nxt_s = pc_plus4_s;
    case (sel_s)
      SEL_SEQ: pc_nxt_s = pc_plus4_s;
      SEL_BR:  pc_nxt_s = br_target_s;
      SEL_J:   pc_nxt_s = j_target_s;
      SEL_JR:  pc_nxt_s = rs_val;
      default: pc_nxt_s = pc_plus4_s;
    endcase
  end

  // control-state transitions
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT: state_nxt_s = RUN;
      RUN: begin
        if (halt_req || (advance_s && jr_mis_s)) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALT:    state_nxt_s = HALT;
      default: state_nxt_s = BOOT;
    endcase
  end

  // state, PC and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC[WIDTH-1:0];
      misalign_r <= 1'b0;
      cmp_err_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (commit_s) begin
        pc_r <= pc_nxt_s;
      end else begin
        pc_r <= pc_r;
      end
      if (advance_s && jr_mis_s) begin
        misalign_r <= 1'b1;
      end else begin
        misalign_r <= misalign_r;
      end
      if (commit_s && is_branch_s && (equal == not_equal)) begin
        cmp_err_r <= 1'b1;
      end else begin
        cmp_err_r <= cmp_err_r;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_branch_s),
    .count (branch_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_taken_s),
    .count (taken_count)
  );

  assign pc       = pc_r;
  assign pc_plus4 = pc_plus4_s;
  assign pc_valid = in_run_s;
  assign halted   = (state_r == HALT);
  assign taken    = in_run_s & (jr | jump | cond_s);
  assign misalign = misalign_r;
  assign cmp_err  = cmp_err_r;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed plus random stimulus against a cycle-level behavioural model of the
// next-PC stage; counters use a narrow width so saturation is reachable.
module tb_pc_branch_unit;

  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic        clk = 1'b0;
  logic        rst_n, stall, beq, bne, jump, jr, equal, not_equal, halt_req;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [63:0] rs_val;
  logic [63:0] pc, pc_plus4;
  logic        pc_valid, taken, halted, misalign, cmp_err;
  logic [CW-1:0] branch_count, taken_count;

  int total = 0;
  int bad   = 0;

  // behavioural model state: 0=boot 1=run 2=halt
  logic [63:0] m_pc;
  int          m_state;
  bit          m_mis, m_cmp, m_known;
  int          m_bc, m_tc;

  always #5 clk = ~clk;

  pc_branch_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .beq(beq), .bne(bne), .jump(jump),
    .jr(jr), .equal(equal), .not_equal(not_equal), .imm(imm), .jtarget(jtarget),
    .rs_val(rs_val), .halt_req(halt_req), .pc(pc), .pc_plus4(pc_plus4),
    .pc_valid(pc_valid), .taken(taken), .halted(halted), .misalign(misalign),
    .cmp_err(cmp_err), .branch_count(branch_count), .taken_count(taken_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_ctl();
    rst_n = 1'b1; stall = 1'b0; beq = 1'b0; bne = 1'b0; jump = 1'b0; jr = 1'b0;
    equal = 1'b0; not_equal = 1'b0; halt_req = 1'b0;
    imm = 16'h0; jtarget = 26'h0; rs_val = 64'h0;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // one clock: check combinational outputs, advance the model, check registered outputs
  task automatic cycle();
    bit          cnd;
    logic [63:0] nxt;
    cnd = (beq && equal) || (bne && not_equal);
    #1;
    if (m_known) begin
      check_eq("taken", {63'd0, taken}, {63'd0, (m_state == 1) && (jr || jump || cnd)});
      check_eq("pc_plus4", pc_plus4, m_pc + 64'd4);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 64'h0; m_state = 0; m_mis = 0; m_cmp = 0; m_bc = 0; m_tc = 0; m_known = 1;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (halt_req) begin
        m_state = 2;
      end else if (!stall) begin
        if (jr && rs_val[1:0] != 2'b00) begin
          m_mis = 1; m_state = 2;
        end else begin
          if ((beq || bne) && (equal == not_equal)) m_cmp = 1;
          if (!jr && !jump) begin
            if (beq || bne) m_bc = sat_inc(m_bc);
            if (cnd) m_tc = sat_inc(m_tc);
          end
          if (jr) nxt = rs_val;
          else if (jump) nxt = {m_pc[63:28] + ((m_pc[27:0] >= 28'hFFFFFFC) ? 36'd1 : 36'd0), jtarget, 2'b00};
          else if (cnd) nxt = m_pc + 64'd4 + 64'(longint'($signed(imm)) * 4);
          else nxt = m_pc + 64'd4;
          m_pc = nxt;
        end
      end
    end
    #1;
    if (m_known) begin
      check_eq("pc", pc, m_pc);
      check_eq("pc_valid", {63'd0, pc_valid}, {63'd0, m_state == 1});
      check_eq("halted", {63'd0, halted}, {63'd0, m_state == 2});
      check_eq("misalign", {63'd0, misalign}, {63'd0, m_mis});
      check_eq("cmp_err", {63'd0, cmp_err}, {63'd0, m_cmp});
      check_eq("branch_count", {60'd0, branch_count}, 64'(m_bc));
      check_eq("taken_count", {60'd0, taken_count}, 64'(m_tc));
    end
  endtask

  initial begin
    m_known = 0; m_pc = 64'h0; m_state = 0; m_mis = 0; m_cmp = 0; m_bc = 0; m_tc = 0;
    clear_ctl();
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();                    // BOOT -> RUN, pc still 0
    cycle(); cycle(); cycle();  // 4, 8, 12

    jump = 1'b1; jtarget = 26'h40; cycle();        // -> 0x100
    clear_ctl(); beq = 1'b1; equal = 1'b1; imm = 16'hFFFC; cycle();  // -> 0xF4
    clear_ctl(); jump = 1'b1; jtarget = 26'h40; cycle();
    clear_ctl(); bne = 1'b1; equal = 1'b1; cycle();  // not taken -> 0x104

    clear_ctl(); stall = 1'b1; beq = 1'b1; equal = 1'b1; imm = 16'h0008;
    cycle(); cycle(); cycle();
    stall = 1'b0; cycle();

    clear_ctl(); jump = 1'b1; beq = 1'b1; equal = 1'b1; jtarget = 26'h40; cycle();
    clear_ctl(); beq = 1'b1; equal = 1'b1; not_equal = 1'b1; cycle();
    clear_ctl(); cycle();

    jr = 1'b1; rs_val = 64'hFFFF_FFFF_FFFF_FFFC; cycle();  // wrap boundary
    clear_ctl(); cycle();

    jr = 1'b1; rs_val = 64'h2002; cycle();                 // misaligned -> HALT
    clear_ctl(); jump = 1'b1; jtarget = 26'h40; cycle(); cycle();
    clear_ctl(); rst_n = 1'b0; cycle();
    rst_n = 1'b1; cycle(); cycle();

    stall = 1'b1; halt_req = 1'b1; cycle();                // halt_req beats stall
    clear_ctl(); cycle();
    rst_n = 1'b0; cycle(); rst_n = 1'b1; cycle();

    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      stall     = ($urandom_range(0, 3) == 0);
      halt_req  = ($urandom_range(0, 60) == 0);
      beq       = $urandom_range(0, 1) == 1;
      bne       = $urandom_range(0, 2) == 0;
      jump      = ($urandom_range(0, 7) == 0);
      jr        = ($urandom_range(0, 9) == 0);
      equal     = $urandom_range(0, 1) == 1;
      not_equal = ($urandom_range(0, 9) == 0) ? equal : ~equal;
      imm       = 16'($urandom);
      jtarget   = 26'($urandom);
      rs_val    = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 5) != 0) rs_val[1:0] = 2'b00;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
